// File: rtl/sm4_req_arbiter.sv
// Two-channel front end for a shared SM4 core: round-robin request arbitration,
// in-order result routing through an owner-tag FIFO, and drain-then-invalidate flush sequencing.
module sm4_req_arbiter #(
    parameter int group_size_p      = 128,
    parameter int max_outstanding_p = 4
) (
    input  logic                                 clk_i,
    input  logic                                 reset_i,
    input  logic                                 r0_v_i,
    input  logic                                 r1_v_i,
    output logic                                 r0_ready_o,
    output logic                                 r1_ready_o,
    input  logic [group_size_p-1:0]              r0_content_i,
    input  logic [group_size_p-1:0]              r1_content_i,
    input  logic [group_size_p-1:0]              r0_key_i,
    input  logic [group_size_p-1:0]              r1_key_i,
    input  logic                                 r0_decode_i,
    input  logic                                 r1_decode_i,
    output logic                                 r0_v_o,
    output logic                                 r1_v_o,
    output logic [group_size_p-1:0]              r0_crypt_o,
    output logic [group_size_p-1:0]              r1_crypt_o,
    input  logic                                 r0_yumi_i,
    input  logic                                 r1_yumi_i,
    input  logic                                 flush_i,
    output logic                                 flush_done_o,
    output logic                                 eng_v_o,
    input  logic                                 eng_ready_i,
    output logic [group_size_p-1:0]              eng_content_o,
    output logic [group_size_p-1:0]              eng_key_o,
    output logic                                 eng_decode_o,
    input  logic                                 eng_v_i,
    input  logic [group_size_p-1:0]              eng_crypt_i,
    output logic                                 eng_yumi_o,
    output logic                                 eng_invalid_cache_o,
    output logic [$clog2(max_outstanding_p):0]   outstanding_o
);

    localparam int aw_lp = $clog2(max_outstanding_p);
    localparam logic [aw_lp-1:0] ptr_one_lp   = 1;
    localparam logic [aw_lp:0]   cnt_one_lp   = 1;
    localparam logic [aw_lp:0]   cnt_full_lp  = max_outstanding_p;

    typedef enum logic [1:0] {RUN, DRAIN, INVAL} state_e;

    state_e                     state;
    logic                       ptr;
    logic [max_outstanding_p-1:0] tag_mem;
    logic [aw_lp-1:0]           wr_ptr;
    logic [aw_lp-1:0]           rd_ptr;
    logic [aw_lp:0]             count;

    logic full, empty, grant, grant_ok, push, pop, head, ret_v;

    assign full  = (count == cnt_full_lp);
    assign empty = (count == '0);

    // Pointer only breaks ties; a lone requester always wins.
    assign grant    = (r0_v_i & r1_v_i) ? ptr : r1_v_i;
    assign grant_ok = reset_i & (state == RUN) & ~full;
    assign eng_v_o  = grant_ok & (grant ? r1_v_i : r0_v_i);
    assign push     = eng_v_o & eng_ready_i;

    assign r0_ready_o = push & ~grant;
    assign r1_ready_o = push & grant;

    assign eng_content_o = !reset_i ? '0 : (grant ? r1_content_i : r0_content_i);
    assign eng_key_o     = !reset_i ? '0 : (grant ? r1_key_i : r0_key_i);
    assign eng_decode_o  = reset_i & (grant ? r1_decode_i : r0_decode_i);

    // The core is in-order, so the FIFO head always names the owner of the result on eng_crypt_i.
    assign head       = tag_mem[rd_ptr];
    assign ret_v      = reset_i & eng_v_i & ~empty;
    assign r0_v_o     = ret_v & ~head;
    assign r1_v_o     = ret_v & head;
    assign r0_crypt_o = (reset_i & ~empty & ~head) ? eng_crypt_i : '0;
    assign r1_crypt_o = (reset_i & ~empty & head) ? eng_crypt_i : '0;
    assign eng_yumi_o = head ? (r1_yumi_i & r1_v_o) : (r0_yumi_i & r0_v_o);
    assign pop        = eng_yumi_o;

    assign eng_invalid_cache_o = (state == INVAL);
    assign flush_done_o        = (state == INVAL);
    assign outstanding_o       = count;

    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            ptr     <= 1'b0;
            tag_mem <= '0;
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count   <= '0;
        end else begin
            if (push) begin
                tag_mem[wr_ptr] <= grant;
                wr_ptr          <= wr_ptr + ptr_one_lp;
                ptr             <= ~grant;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + ptr_one_lp;
            end
            case ({push, pop})
                2'b10:   count <= count + cnt_one_lp;
                2'b01:   count <= count - cnt_one_lp;
                default: count <= count;
            endcase
        end
    end

    // Dropping flush_i while draining abandons the flush without an invalidate pulse.
    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            state <= RUN;
        end else begin
            case (state)
                RUN:     if (flush_i) state <= DRAIN;
                DRAIN: begin
                    if (!flush_i)                 state <= RUN;
                    else if (empty && !push)      state <= INVAL;
                end
                INVAL:   state <= RUN;
                default: state <= RUN;
            endcase
        end
    end

endmodule

// File: tb/tb_sm4_req_arbiter.sv
// Scoreboard bench for sm4_req_arbiter: a behavioural model predicts grants and
// routing each cycle while a fake in-order core echoes accepted blocks back.
module tb_sm4_req_arbiter;

    localparam int W = 128;
    localparam int D = 4;
    localparam logic [127:0] VEC_IN  = 128'h0123456789abcdeffedcba9876543210;
    localparam logic [127:0] VEC_OUT = 128'h681edf34d206965e86b3e94f536e4246;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rstN;
    logic         r0V, r1V, r0Ready, r1Ready;
    logic [W-1:0] r0Content, r1Content, r0Key, r1Key;
    logic         r0Decode, r1Decode;
    logic         r0VOut, r1VOut;
    logic [W-1:0] r0Crypt, r1Crypt;
    logic         r0Yumi, r1Yumi;
    logic         flush, flushDone;
    logic         engV, engReady;
    logic [W-1:0] engContent, engKey;
    logic         engDecode, engVIn;
    logic [W-1:0] engCrypt;
    logic         engYumi, engInval;
    logic [2:0]   outstanding;

    sm4_req_arbiter #(.group_size_p(W), .max_outstanding_p(D)) dut (
        .clk_i(clk), .reset_i(rstN),
        .r0_v_i(r0V), .r1_v_i(r1V), .r0_ready_o(r0Ready), .r1_ready_o(r1Ready),
        .r0_content_i(r0Content), .r1_content_i(r1Content),
        .r0_key_i(r0Key), .r1_key_i(r1Key),
        .r0_decode_i(r0Decode), .r1_decode_i(r1Decode),
        .r0_v_o(r0VOut), .r1_v_o(r1VOut), .r0_crypt_o(r0Crypt), .r1_crypt_o(r1Crypt),
        .r0_yumi_i(r0Yumi), .r1_yumi_i(r1Yumi),
        .flush_i(flush), .flush_done_o(flushDone),
        .eng_v_o(engV), .eng_ready_i(engReady),
        .eng_content_o(engContent), .eng_key_o(engKey), .eng_decode_o(engDecode),
        .eng_v_i(engVIn), .eng_crypt_i(engCrypt), .eng_yumi_o(engYumi),
        .eng_invalid_cache_o(engInval), .outstanding_o(outstanding)
    );

    typedef struct packed {
        logic         owner;
        logic [127:0] crypt;
    } exp_t;

    typedef enum {M_RUN, M_DRAIN, M_INVAL} mstate_e;

    exp_t         expQ[$];
    logic [127:0] coreQ[$];
    mstate_e      mState;
    logic         mPtr;
    logic         coreEn, spurious;
    logic         lastDone;
    int           doneCount;
    int           maxOut;
    int           checks = 0;
    int           errors = 0;

    task automatic checkOutput(input string tag, input logic [127:0] observed, input logic [127:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Stand-in for the SM4 core: the known test vector, otherwise an arbitrary reversible mix.
    function automatic logic [127:0] coreFn(input logic [127:0] c, input logic [127:0] k, input logic d);
        if (c == VEC_IN && k == VEC_IN && !d) return VEC_OUT;
        return c ^ {k[63:0], k[127:64]} ^ {128{d}};
    endfunction

    task automatic randomizeReqs();
        r0Content = {$urandom, $urandom, $urandom, $urandom};
        r1Content = {$urandom, $urandom, $urandom, $urandom};
        r0Key     = {$urandom, $urandom, $urandom, $urandom};
        r1Key     = {$urandom, $urandom, $urandom, $urandom};
        r0Decode  = 1'($urandom_range(0, 1));
        r1Decode  = 1'($urandom_range(0, 1));
    endtask

    // One clock cycle: drive the core side, predict, compare, then advance model and core.
    task automatic applyStimulus();
        logic fullM, gok, g, ev, acc, rv, h, yum;
        logic [127:0] gContent, gKey;
        logic gDec;
        int sz;
        engVIn   = spurious | (coreEn && coreQ.size() > 0);
        engCrypt = (coreQ.size() > 0) ? coreQ[0] : '0;
        #3;
        sz    = expQ.size();
        fullM = (sz == D);
        gok   = rstN && mState == M_RUN && !fullM;
        g     = (r0V && r1V) ? mPtr : r1V;
        ev    = gok && (g ? r1V : r0V);
        acc   = ev && engReady;
        gContent = g ? r1Content : r0Content;
        gKey     = g ? r1Key : r0Key;
        gDec     = g ? r1Decode : r0Decode;
        h     = (sz > 0) ? expQ[0].owner : 1'b0;
        rv    = rstN && engVIn && sz > 0;
        yum   = rv && (h ? r1Yumi : r0Yumi);

        checkOutput("eng_v", 128'(engV), 128'(ev));
        checkOutput("ready", 128'({r1Ready, r0Ready}), 128'({acc && g, acc && !g}));
        if (ev) begin
            checkOutput("eng_content", engContent, gContent);
            checkOutput("eng_key", engKey, gKey);
            checkOutput("eng_decode", 128'(engDecode), 128'(gDec));
        end
        if (!rstN) begin
            checkOutput("rst_data", engContent | engKey | r0Crypt | r1Crypt, '0);
        end
        checkOutput("ret_v", 128'({r1VOut, r0VOut}), 128'({rv && h, rv && !h}));
        if (rv && !h) checkOutput("r0_crypt", r0Crypt, expQ[0].crypt);
        if (rv && h)  checkOutput("r1_crypt", r1Crypt, expQ[0].crypt);
        checkOutput("eng_yumi", 128'(engYumi), 128'(yum));
        checkOutput("inval", 128'({flushDone, engInval}), (rstN && mState == M_INVAL) ? 128'(3) : 128'(0));
        checkOutput("outstanding", 128'(outstanding), rstN ? 128'(sz) : 128'(0));

        lastDone = flushDone;
        if (flushDone) doneCount++;
        if (int'(outstanding) > maxOut) maxOut = int'(outstanding);

        // Core environment reacts to what the DUT actually did.
        if (!rstN) begin
            coreQ.delete();
        end else begin
            if (engYumi && coreQ.size() > 0) void'(coreQ.pop_front());
            if (engV && engReady) coreQ.push_back(coreFn(engContent, engKey, engDecode));
        end

        if (!rstN) begin
            expQ.delete();
            mPtr   = 1'b0;
            mState = M_RUN;
        end else begin
            if (yum) void'(expQ.pop_front());
            if (acc) begin
                expQ.push_back('{owner: g, crypt: coreFn(gContent, gKey, gDec)});
                mPtr = !g;
            end
            case (mState)
                M_RUN:   if (flush) mState = M_DRAIN;
                M_DRAIN: if (!flush) mState = M_RUN; else if (sz == 0) mState = M_INVAL;
                default: mState = M_RUN;
            endcase
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] simulation hung");
    end

    initial begin
        int at;
        bit seen;
        rstN = 1'b0; r0V = 0; r1V = 0; r0Yumi = 0; r1Yumi = 0; flush = 0;
        engReady = 1; coreEn = 1; spurious = 0;
        r0Content = '0; r1Content = '0; r0Key = '0; r1Key = '0; r0Decode = 0; r1Decode = 0;
        engVIn = 0; engCrypt = '0;
        mState = M_RUN; mPtr = 0; lastDone = 0; doneCount = 0; maxOut = 0;
        @(posedge clk); #1;
        r0V = 1; r1V = 1;
        applyStimulus();
        applyStimulus();
        r0V = 0; r1V = 0;
        rstN = 1'b1;
        applyStimulus();

        $display("[TB] single channel known vector");
        r0V = 1; r0Content = VEC_IN; r0Key = VEC_IN; r0Decode = 0;
        r0Yumi = 1; r1Yumi = 1;
        applyStimulus();
        r0V = 0;
        applyStimulus();
        applyStimulus();

        $display("[TB] alternating grants");
        r0V = 1; r1V = 1;
        for (int i = 0; i < 10; i++) begin
            randomizeReqs();
            applyStimulus();
        end

        $display("[TB] fill tag fifo");
        maxOut = 0;
        r1Yumi = 0;
        for (int i = 0; i < 8; i++) begin
            randomizeReqs();
            applyStimulus();
        end
        checkOutput("fill_max", 128'(maxOut), 128'(D));
        r1Yumi = 1;
        for (int i = 0; i < 3; i++) applyStimulus();
        r0V = 0; r1V = 0;
        for (int i = 0; i < 6; i++) applyStimulus();

        $display("[TB] flush with work in flight");
        coreEn = 0; r0V = 1;
        for (int i = 0; i < 3; i++) begin
            randomizeReqs();
            applyStimulus();
        end
        flush = 1;
        for (int i = 0; i < 3; i++) applyStimulus();
        coreEn = 1;
        seen = 0;
        for (int i = 0; i < 20 && !seen; i++) begin
            applyStimulus();
            if (lastDone) seen = 1;
        end
        checkOutput("flush_done_seen", 128'(seen), 128'(1));
        flush = 0; r0V = 0;
        for (int i = 0; i < 3; i++) applyStimulus();

        $display("[TB] flush with empty fifo");
        flush = 1; at = -1;
        for (int i = 0; i < 3; i++) begin
            applyStimulus();
            if (lastDone) at = i;
        end
        checkOutput("flush_latency", 128'(at), 128'(2));
        flush = 0;
        applyStimulus();

        $display("[TB] aborted flush");
        coreEn = 0; r0V = 1;
        randomizeReqs();
        applyStimulus();
        r0V = 0; flush = 1;
        doneCount = 0;
        applyStimulus();
        applyStimulus();
        flush = 0;
        for (int i = 0; i < 3; i++) applyStimulus();
        coreEn = 1;
        for (int i = 0; i < 3; i++) applyStimulus();
        checkOutput("abort_no_pulse", 128'(doneCount), 128'(0));

        $display("[TB] result valid with empty fifo");
        spurious = 1;
        applyStimulus();
        spurious = 0;

        $display("[TB] reset mid-operation");
        coreEn = 0; r0V = 1; r1V = 1;
        randomizeReqs();
        applyStimulus();
        applyStimulus();
        checkOutput("pre_reset_outstanding", 128'(outstanding), 128'(2));
        rstN = 0;
        applyStimulus();
        rstN = 1;
        randomizeReqs();
        applyStimulus();
        coreEn = 1; r0V = 0; r1V = 0;
        for (int i = 0; i < 4; i++) applyStimulus();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
